// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO (UART_TX_PARITY_EN adds an even-parity bit).
// Latency: a byte stored into an empty FIFO while idle is popped on the next edge; the start bit follows that edge.
// Backpressure: stores to a full FIFO are dropped and set a sticky overrun flag, cleared by reading STATUS.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TxD,
    output logic        Busy
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]       STAT_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [7:0]        shift, shift_nxt;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              ovr;

    logic wr_hit, rd_stat, full, empty, active, pop, push, overflow, baud_last;
    logic unused_wdata;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
`endif

    assign unused_wdata = ^WriteData[31:8];

    assign wr_hit    = MemWrite && (Address == BASE_ADDR);
    assign rd_stat   = MemRead && (Address == STAT_ADDR);
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign active    = (state != S_IDLE);
    assign baud_last = (baud_cnt == BAUD_LAST);

    // A pop on the same edge frees a slot, so a store to a full FIFO still lands.
    assign push     = wr_hit && (!full || pop);
    assign overflow = wr_hit && full && !pop;

    assign ReadData = rd_stat ? {28'd0, ovr, active, empty, full} : 32'd0;
    assign Busy     = !empty || active;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovr      <= 1'b0;
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // An overrun on the same edge as the clearing read wins.
            if (overflow) begin
                ovr <= 1'b1;
            end else if (rd_stat) begin
                ovr <= 1'b0;
            end
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
`ifdef UART_TX_PARITY_EN
            if (pop) begin
                par_bit <= ^mem[rd_ptr];
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    state_nxt = S_START;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = S_STOP;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                baud_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        TxD = 1'b1;
        case (state)
            S_START:  TxD = 1'b0;
            S_DATA:   TxD = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: TxD = par_bit;
`endif
            default:  TxD = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h1001_0024;
    localparam logic [31:0] STAT = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        TxD;
    logic        Busy;

    int n_cmp;
    int n_err;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Address  (Address),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .TxD      (TxD),
        .Busy     (Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;
    endtask

    task automatic store(input logic [7:0] b);
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        Address   = BASE;
        WriteData = {24'hABCDEF, b};
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        MemRead = 1'b1;
        Address = STAT;
        #1;
        check(tag, ReadData, exp);
        MemRead = 1'b0;
        Address = 32'd0;
    endtask

    // Waits for a start bit, then samples each bit mid-cell; returns on the cycle after STOP.
    task automatic rx_frame(output logic [7:0] d, output int gap);
        logic [7:0] r;
        r   = 8'h00;
        gap = 0;
        while (TxD !== 1'b0 && gap < 100) begin
            tick();
            gap++;
        end
        check("rx_start_seen", 32'(gap < 100), 32'd1);
        repeat (CPB / 2) tick();
        check("rx_start_bit", TxD, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            r[i] = TxD;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) tick();
        check("rx_parity", TxD, ^r);
`endif
        repeat (CPB) tick();
        check("rx_stop", TxD, 1'b1);
        repeat (CPB / 2) tick();
        d = r;
    endtask

    logic [7:0]    d;
    int            gap;
    logic [NB-1:0] e_bits;
    logic [7:0]    a5;
    logic [7:0]    exp_q [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus_idle();
        #3;
        check("rst_txd", TxD, 1'b1);
        check("rst_busy", Busy, 1'b0);
        read_status("rst_status", 32'h2);

        // Stores while reset is held must not enter the FIFO.
        store(8'h55);
        tick();
        tick();
        bus_idle();
        reset = 1'b1;
        check("rst_store_busy", Busy, 1'b0);
        read_status("rst_store_status", 32'h2);
        tick();

        // Single 0xA5 frame, bit by bit.
        store(8'hA5);
        tick();
        bus_idle();
        check("a5_busy_queued", Busy, 1'b1);
        check("a5_txd_before_pop", TxD, 1'b1);
        read_status("a5_status_queued", 32'h0);
        tick();
        a5        = 8'hA5;
        e_bits    = '1;
        e_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e_bits[i + 1] = a5[i];
`ifdef UART_TX_PARITY_EN
        e_bits[9] = ^a5;
`endif
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("a5_bit%0d_cyc%0d", b, c), TxD, e_bits[b]);
                tick();
            end
        end
        check("a5_busy_done", Busy, 1'b0);
        check("a5_txd_done", TxD, 1'b1);
        read_status("a5_status_done", 32'h2);
        tick();

        // Fill the FIFO behind an active frame and overrun it.
        store(8'h11);
        tick();
        bus_idle();
        tick();
        check("ovf_frame_started", TxD, 1'b0);
        for (int k = 0; k < 5; k++) begin
            store(8'h21 + 8'(k));
            tick();
        end
        bus_idle();
        tick();
        MemRead = 1'b1;
        Address = STAT;
        #1;
        check("ovf_status", ReadData, 32'hD);
        tick();
        check("ovf_cleared", ReadData, 32'h5);
        bus_idle();

        // Frame 0x11 ends; store lands on the same edge as the IDLE pop of a full FIFO.
        repeat (33) tick();
        read_status("full_idle_status", 32'h1);
        check("full_idle_txd", TxD, 1'b1);
        store(8'h26);
        tick();
        bus_idle();
        read_status("pushpop_full_status", 32'h5);
        exp_q[0] = 8'h21;
        exp_q[1] = 8'h22;
        exp_q[2] = 8'h23;
        exp_q[3] = 8'h24;
        exp_q[4] = 8'h26;
        for (int i = 0; i < 5; i++) begin
            rx_frame(d, gap);
            check($sformatf("order_byte%0d", i), d, exp_q[i]);
            check($sformatf("order_gap%0d", i), gap, (i == 0) ? 0 : 1);
        end
        check("order_busy_done", Busy, 1'b0);
        read_status("order_status_done", 32'h2);
        tick();

        // Accesses outside the two registers.
        MemWrite  = 1'b1;
        Address   = BASE + 32'd8;
        WriteData = 32'h77;
        tick();
        bus_idle();
        check("bad_store_busy", Busy, 1'b0);
        read_status("bad_store_status", 32'h2);
        tick();
        MemRead = 1'b1;
        Address = BASE;
        #1;
        check("load_txdata_zero", ReadData, 32'h0);
        Address = BASE + 32'd8;
        #1;
        check("load_other_zero", ReadData, 32'h0);
        MemRead = 1'b0;
        Address = STAT;
        #1;
        check("no_strobe_zero", ReadData, 32'h0);
        bus_idle();
        tick();

        // Asynchronous reset in the middle of data bit 1 of 0x3C (a zero bit).
        store(8'h3C);
        tick();
        bus_idle();
        tick();
        repeat (10) tick();
        check("pre_rst_txd", TxD, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst_txd", TxD, 1'b1);
        check("async_rst_busy", Busy, 1'b0);
        read_status("async_rst_status", 32'h2);
        tick();
        reset = 1'b1;
        store(8'h00);
        tick();
        bus_idle();
        rx_frame(d, gap);
        check("post_rst_byte", d, 8'h00);
        check("post_rst_gap", gap, 1);
        check("post_rst_busy", Busy, 1'b0);
        tick();

        // 0x07 has odd weight: parity bit is 1 when parity is enabled.
        store(8'h07);
        tick();
        bus_idle();
        rx_frame(d, gap);
        check("byte07", d, 8'h07);
        check("byte07_gap", gap, 1);
        read_status("final_status", 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
